// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into SEG-bit ripple segments, one
// segment per pipeline stage, with the inter-segment carry registered between
// stages. Operands are skewed into their stage and segment sums are deskewed,
// so every segment of one addition reaches the output on the same cycle.
// The valid/ready handshake freezes the whole pipeline while the output is
// held. The pipeline is its own control: the only state besides data is the
// valid shift chain.
// Optional feature: define PIPE_ADDER_OVF_EN to add the signed-overflow
// output `ovf`.

// Fixed-depth delay line that advances only when `adv` is high.
module pipelined_adder_dly #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         adv,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

    // Shift by one slot on advance; hold every slot while stalled.
    always_comb begin
        pipe_d = pipe_q;
        if (adv) begin
            pipe_d[0] = d;
            for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
        end
    end

    // Delay-line registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) pipe_q <= '0;
        else       pipe_q <= pipe_d;
    end

    assign q = pipe_q[DEPTH-1];
endmodule

// One adder segment: operand skew, registered ripple add, and sum deskew.
module pipelined_adder_stage #(
    parameter int SEG    = 8,
    parameter int SKEW   = 0,
    parameter int DESKEW = 0
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic           adv,
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           cy_in,
    output logic           cy_q,
    output logic [SEG-1:0] sum_seg
);
    logic [SEG-1:0] sa, sb;
    logic [SEG-1:0] sum_q, sum_d;
    logic           cy_d;
    logic [SEG:0]   add;

    // Delay this segment's operands until the carry from below arrives.
    if (SKEW > 0) begin : g_skew
        logic [2*SEG-1:0] skew_q;
        pipelined_adder_dly #(.W(2*SEG), .DEPTH(SKEW)) u_skew (
            .clk(clk), .rstN(rstN), .adv(adv), .d({a_seg, b_seg}), .q(skew_q)
        );
        assign sa = skew_q[2*SEG-1:SEG];
        assign sb = skew_q[SEG-1:0];
    end else begin : g_noskew
        assign sa = a_seg;
        assign sb = b_seg;
    end

    // Ripple-carry segment add; the registered carry feeds the next stage.
    always_comb begin
        add   = {1'b0, sa} + {1'b0, sb} + {{SEG{1'b0}}, cy_in};
        sum_d = sum_q;
        cy_d  = cy_q;
        if (adv) begin
            sum_d = add[SEG-1:0];
            cy_d  = add[SEG];
        end
    end

    // Segment sum and carry registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sum_q <= '0;
            cy_q  <= 1'b0;
        end else begin
            sum_q <= sum_d;
            cy_q  <= cy_d;
        end
    end

    // Hold the finished segment until the top segment catches up.
    if (DESKEW > 0) begin : g_deskew
        pipelined_adder_dly #(.W(SEG), .DEPTH(DESKEW)) u_deskew (
            .clk(clk), .rstN(rstN), .adv(adv), .d(sum_q), .q(sum_seg)
        );
    end else begin : g_nodeskew
        assign sum_seg = sum_q;
    end
endmodule

module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cIn,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] sum,
    output logic             cOut,
    output logic             outValid,
    input  logic             outReady
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int STAGES = WIDTH / SEG;

    logic                        adv;
    logic [STAGES:0]             vld_pipe;
    logic [STAGES-1:0]           vld_q, vld_d;
    logic [STAGES:0]             cy_ch;
    logic [STAGES-1:0][SEG-1:0]  a_seg, b_seg, sum_seg;

    // The pipeline only freezes when a valid result is being refused;
    // bubbles at the output never block.
    assign adv      = !(outValid && !outReady);
    assign inReady  = adv;
    assign outValid = vld_q[STAGES-1];

    assign vld_pipe = {vld_q, inValid && adv};

    // Valid chain: a bubble enters whenever no transaction is accepted.
    always_comb begin
        vld_d = vld_q;
        if (adv) vld_d = vld_pipe[STAGES-1:0];
    end

    // Valid-bit registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) vld_q <= '0;
        else       vld_q <= vld_d;
    end

    assign a_seg    = a;
    assign b_seg    = b;
    assign cy_ch[0] = cIn;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipelined_adder_stage #(
            .SEG(SEG), .SKEW(k), .DESKEW(STAGES - 1 - k)
        ) u_stage (
            .clk     (clk),
            .rstN    (rstN),
            .adv     (adv),
            .a_seg   (a_seg[k]),
            .b_seg   (b_seg[k]),
            .cy_in   (cy_ch[k]),
            .cy_q    (cy_ch[k+1]),
            .sum_seg (sum_seg[k])
        );
    end

    assign sum  = sum_seg;
    assign cOut = cy_ch[STAGES];

`ifdef PIPE_ADDER_OVF_EN
    // Carry into the MSB is a_msb ^ b_msb ^ sum_msb; overflow is that carry
    // differing from cOut. The operand MSBs ride a STAGES-deep delay so every
    // term is a register aligned with sum; all-zero reset gives ovf=0.
    logic [1:0] msb_q;
    pipelined_adder_dly #(.W(2), .DEPTH(STAGES)) u_msb (
        .clk(clk), .rstN(rstN), .adv(adv),
        .d({a[WIDTH-1], b[WIDTH-1]}), .q(msb_q)
    );
    assign ovf = msb_q[1] ^ msb_q[0] ^ sum[WIDTH-1] ^ cOut;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vector table, random streams against a
// queue-based reference model, stall/reset sequences and a single-stage build.
module tb_pipelined_adder;
    localparam int W  = 32;
    localparam int S  = 8;
    localparam int ST = W / S;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          cIn = 1'b0, inValid = 1'b0, outReady = 1'b1;
    logic          inReady, outValid, cOut;
    logic [W-1:0]  sum;

    logic [15:0]   a1 = '0, b1 = '0;
    logic          cIn1 = 1'b0, inValid1 = 1'b0, outReady1 = 1'b1;
    logic          inReady1, outValid1, cOut1;
    logic [15:0]   sum1;
`ifdef PIPE_ADDER_OVF_EN
    logic          ovf, ovf1;
`endif

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .SEG(S)) dut (
        .clk(clk), .rstN(rstN), .a(a), .b(b), .cIn(cIn), .inValid(inValid),
        .inReady(inReady), .sum(sum), .cOut(cOut), .outValid(outValid),
        .outReady(outReady)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipelined_adder #(.WIDTH(16), .SEG(16)) dut1 (
        .clk(clk), .rstN(rstN), .a(a1), .b(b1), .cIn(cIn1), .inValid(inValid1),
        .inReady(inReady1), .sum(sum1), .cOut(cOut1), .outValid(outValid1),
        .outReady(outReady1)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [32:0] res;
        logic        ov;
        int          cyc;
        int          stl;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          stalls = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_out = '0;
    logic [32:0] pend_res = '0;
    logic        pend_ov = 1'b0;

    // Settle, then score the output transfer and log an input acceptance,
    // both of which take effect on the coming rising edge.
    task automatic observe();
        exp_t e;
        #1;
        if (prev_stall) begin
            chk("stall_hold_data", {cOut, sum}, prev_out);
            chk("stall_hold_valid", outValid, 1'b1);
        end
        chk("in_ready", inReady, !(outValid && !outReady));
        if (outValid && outReady) begin
            if (sb.size() == 0) begin
                chk("spurious_out", outValid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("result", {cOut, sum}, e.res);
                chk("latency", cyc - e.cyc, ST + stalls - e.stl);
`ifdef PIPE_ADDER_OVF_EN
                chk("ovf", ovf, e.ov);
`endif
            end
        end
        if (outValid && !outReady) stalls++;
        prev_stall = outValid && !outReady;
        prev_out   = {cOut, sum};
        if (inValid && inReady) begin
            e.res = pend_res; e.ov = pend_ov; e.cyc = cyc; e.stl = stalls;
            sb.push_back(e);
        end
    endtask

    task automatic cycle_drv(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                             input logic ic, input logic [32:0] eres, input logic eov,
                             input logic rdy);
        @(posedge clk);
        cyc++;
        #1;
        inValid = v; a = ia; b = ib; cIn = ic; outReady = rdy;
        pend_res = eres; pend_ov = eov;
        observe();
    endtask

    // Reference: plain unsigned sum; overflow when like-signed operands give
    // a result of the other sign.
    task automatic rnd_drv(input logic v, input logic rdy);
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] r;
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
        r  = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
        cycle_drv(v, ra, rb, rc, r, (ra[31] == rb[31]) && (r[31] != ra[31]), rdy);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 60) begin
            rnd_drv(1'b0, 1'b1);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        ci;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [15:0] a, b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec16_t;

    initial begin
        vec_t   tbl[8];
        vec16_t t16[3];
        tbl[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[1] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[3] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
        tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[6] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        tbl[7] = '{32'h00FF00FF, 32'h00010001, 1'b1, 32'h01000101, 1'b0, 1'b0};
        t16[0] = '{16'h1234, 16'h0FFF, 1'b1, 16'h2234, 1'b0, 1'b0};
        t16[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        t16[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        // Reset state.
        #3;
        chk("rst_sum", sum, 32'h0);
        chk("rst_cout", cOut, 1'b0);
        chk("rst_valid", outValid, 1'b0);
        chk("rst_in_ready", inReady, 1'b1);
        @(negedge clk);
        rstN = 1'b1;

        // Directed table, one isolated transaction each with exact latency.
        for (int i = 0; i < 8; i++) begin
            cycle_drv(1'b1, tbl[i].a, tbl[i].b, tbl[i].ci, {tbl[i].co, tbl[i].s}, tbl[i].ov, 1'b1);
            for (int j = 0; j < ST - 1; j++) begin
                rnd_drv(1'b0, 1'b1);
                chk("early_valid", outValid, 1'b0);
            end
            rnd_drv(1'b0, 1'b1);
            chk("tbl_valid", outValid, 1'b1);
            chk("tbl_sum", sum, tbl[i].s);
            chk("tbl_cout", cOut, tbl[i].co);
        end
        drain();

        // Back-to-back random stream.
        for (int i = 0; i < 100; i++) rnd_drv(1'b1, 1'b1);
        drain();

        // Output held for 5 cycles while full; offered inputs must be ignored.
        for (int i = 0; i < 6; i++) rnd_drv(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rnd_drv(1'b1, 1'b0);
            chk("stall_in_ready", inReady, 1'b0);
        end
        drain();

        // outReady low with only bubbles at the output: no stall.
        rnd_drv(1'b1, 1'b0);
        rnd_drv(1'b0, 1'b0);
        rnd_drv(1'b0, 1'b0);
        chk("bubble_no_stall", inReady, 1'b1);
        drain();

        // Random valid / ready mix.
        for (int i = 0; i < 300; i++)
            rnd_drv(1'(($urandom_range(0, 2)) != 0), 1'(($urandom_range(0, 3)) != 0));
        drain();

        // Reset with 3 transactions in flight.
        for (int i = 0; i < 3; i++) rnd_drv(1'b1, 1'b1);
        rstN = 1'b0;
        inValid = 1'b0;
        #1;
        chk("midrst_sum", sum, 32'h0);
        chk("midrst_cout", cOut, 1'b0);
        chk("midrst_valid", outValid, 1'b0);
        chk("midrst_in_ready", inReady, 1'b1);
        sb.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < ST + 3; i++) begin
            rnd_drv(1'b0, 1'b1);
            chk("midrst_no_out", outValid, 1'b0);
        end

        // Single-stage build: registered adder with latency 1.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            a1 = t16[i].a; b1 = t16[i].b; cIn1 = t16[i].ci; inValid1 = 1'b1;
            @(posedge clk);
            #1;
            inValid1 = 1'b0;
            #1;
            chk("s1_valid", outValid1, 1'b1);
            chk("s1_sum", sum1, t16[i].s);
            chk("s1_cout", cOut1, t16[i].co);
`ifdef PIPE_ADDER_OVF_EN
            chk("s1_ovf", ovf1, t16[i].ov);
`endif
            @(posedge clk);
            #2;
            chk("s1_bubble", outValid1, 1'b0);
            chk("s1_in_ready", inReady1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, segment-pipelined adder: `WIDTH`-bit operands are split into `SEG`-bit segments, one ripple-carry segment per pipeline stage, with the inter-segment carry registered between stages. It accepts one addition per cycle under a valid/ready handshake and supports back-pressure. It is the datapath adder for the wider arithmetic units and supersedes the fixed-width, purely combinational chained-segment adders.

## Interface
- `WIDTH`, 32, operand and sum width in bits; must be a multiple of `SEG`.
- `SEG`, 8, segment width in bits (≥1); `STAGES = WIDTH/SEG`.
- `clk` input 1 — single clock, rising edge.
- `rstN` input 1 — reset, asynchronous, active-low.
- `a` input WIDTH — operand A.
- `b` input WIDTH — operand B.
- `cIn` input 1 — carry in to segment 0.
- `inValid` input 1 — `a`/`b`/`cIn` valid this cycle.
- `inReady` output 1 — adder can accept this cycle.
- `sum` output WIDTH — result, aligned to `outValid`.
- `cOut` output 1 — carry out of the top segment.
- `outValid` output 1 — `sum`/`cOut` valid.
- `outReady` input 1 — downstream accepts this cycle.
- `ovf` output 1 — signed overflow (only with `PIPE_ADDER_OVF_EN`).

## Operation
- Stage k (0..STAGES-1) adds segment k of A and B plus the carry registered by stage k-1 (stage 0 uses `cIn`); it registers its segment sum and carry-out.
- Operand skew: segment k operands are delayed k cycles before stage k; deskew: segment k sum is delayed STAGES-1-k cycles after stage k, so all segments of one transaction reach the output together.
- Each stage carries a valid bit; a transaction enters with its valid set on the edge where `inValid && inReady`; otherwise a bubble (valid=0) enters.
- Stall = `outValid && !outReady`. `inReady = !stall` (combinational).
- No stall: every stage register advances each edge; bubbles propagate and may collapse nowhere (fixed latency).
- Stall: all stage, skew and deskew registers hold; `sum`, `cOut`, `outValid` stable; input ignored.
- Output transfer on edge where `outValid && outReady`.
- Arithmetic: `{cOut, sum} = a + b + cIn` modulo 2^(WIDTH+1); unsigned, no saturation.
- Data registers of bubbles are don't-care internally but `sum`/`cOut` are only meaningful while `outValid`=1.
- No state machine beyond the valid shift chain; pipeline is its own control.

## Timing
- Reset (async assert on `rstN`=0): all valid bits 0, all data registers 0; outputs `sum`=0, `cOut`=0, `outValid`=0, `ovf`=0; `inReady`=1 during and after reset.
- Reset deassertion is synchronised by the integrator; first acceptance possible on the first rising edge with `rstN`=1.
- Latency: transaction accepted at edge N appears with `outValid`=1 after edge N+STAGES (STAGES cycles), absent stalls; each stall cycle adds one cycle.
- Throughput: one per cycle when `outReady`=1.
- `STAGES`=1 (`SEG`=`WIDTH`): single registered adder, latency 1.
- Reset mid-operation: all in-flight transactions discarded, no partial result emitted.
- Simultaneous output transfer and input acceptance in the same cycle is legal and required.
- `outReady` low while `outValid`=0: pipeline still advances (no stall on bubbles).

## Configuration
- `PIPE_ADDER_OVF_EN` defined: `ovf` port present; computed in the last stage from the top-segment carry-in and carry-out (`ovf = c_in_msb ^ cOut`), registered and aligned with `sum`; held during stall; reset 0.
- Undefined: `ovf` port and its logic absent; all other behaviour identical.

## Test plan
- WIDTH=32,SEG=8: after reset check `sum`=0,`cOut`=0,`outValid`=0,`inReady`=1; then `a`=0xFFFFFFFF,`b`=0,`cIn`=1 -> 4 cycles later `sum`=0x00000000,`cOut`=1, full carry ripple across all stages.
- Back-to-back stream of 100 random triples with `outReady`=1 -> one result per cycle, each equal to `a+b+cIn`, order preserved, latency 4.
- Hold `outReady`=0 for 5 cycles with output valid -> `inReady`=0, `sum`/`cOut` unchanged, no loss or duplication after release.
- Assert `rstN`=0 with 3 transactions in flight -> outputs 0 immediately, no result emitted after release.
- With `PIPE_ADDER_OVF_EN`: `a`=0x7FFFFFFF,`b`=1,`cIn`=0 -> `sum`=0x80000000,`ovf`=1,`cOut`=0; `a`=0x80000000,`b`=0x80000000 -> `sum`=0,`cOut`=1,`ovf`=1.
- WIDTH=16,SEG=16: `a`=0x1234,`b`=0x0FFF,`cIn`=1 -> next cycle `sum`=0x2234,`cOut`=0.
